seq_div: RTL and testbench

//   Multi-cycle unsigned restoring divider; inverse companion of the combinational

---
 rtl/seq_div.sv | 176 +++++++++++++++++
 tb/tb_seq_div.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// ---------------------------------------------------------------------------
// seq_div - multi-cycle unsigned restoring divider
//
// Computes Dividend / Divisor one quotient bit per clock. It sits beside the
// combinational multiplier in the ALU datapath and uses a start/done handshake.
// Quotient, Remainder and div_zero are loaded only on completion. They hold
// their values until the next completion or reset, so they never show
// partial results.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start      request, sampled only while ready=1
//   Dividend   unsigned dividend, captured on the accept edge
//   Divisor    unsigned divisor, captured on the accept edge
//   ready      1 while idle
//   busy       1 while iterating
//   done       one-cycle pulse, result valid
//   Quotient   registered quotient
//   Remainder  registered remainder
//   div_zero   registered: last result had Divisor==0
//
// States
//   state  | meaning
//   S_IDLE | waiting for start, operands not yet captured
//   S_RUN  | one restoring step per clock, DIVIDEND_W steps
//   S_DONE | result registered, done pulse, returns to idle
// ---------------------------------------------------------------------------
module seq_div #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] Dividend,
    input  logic [DIVISOR_W-1:0]  Divisor,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] Quotient,
    output logic [DIVISOR_W-1:0]  Remainder,
    output logic                  div_zero
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [DIVISOR_W:0]     r_q,         r_d;
    logic [DIVIDEND_W-1:0]  q_sh_q,      q_sh_d;
    logic [DIVISOR_W-1:0]   dvs_q,       dvs_d;
    logic [DIVIDEND_W-1:0]  quotient_q,  quotient_d;
    logic [DIVISOR_W-1:0]   remainder_q, remainder_d;
    logic                   div_zero_q,  div_zero_d;
    logic                   ready_q,     ready_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;

    // One restoring step on the current partial remainder / shift register.
    logic [DIVISOR_W:0]     r_shift;
    logic [DIVISOR_W:0]     r_sub;
    logic                   r_ge;
    logic [DIVISOR_W:0]     r_step;
    logic [DIVIDEND_W-1:0]  q_step;

    always_comb begin
        r_shift = {r_q[DIVISOR_W-1:0], q_sh_q[DIVIDEND_W-1]};
        r_sub   = r_shift - {1'b0, dvs_q};
        r_ge    = (r_shift >= {1'b0, dvs_q});
        r_step  = r_ge ? r_sub : r_shift;
        q_step  = {q_sh_q[DIVIDEND_W-2:0], r_ge};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_sh_d      = q_sh_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvs_d   = Divisor;
                    r_d     = '0;
                    q_sh_d  = Dividend;
                    cnt_d   = '0;
                    state_d = S_RUN;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                r_d    = r_step;
                q_sh_d = q_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // A zero divisor runs the same path so latency is uniform;
                    // only the published result is overridden.
                    if (dvs_q == '0) begin
                        quotient_d  = '1;
                        remainder_d = '0;
                        div_zero_d  = 1'b1;
                    end else begin
                        quotient_d  = q_step;
                        remainder_d = r_step[DIVISOR_W-1:0];
                        div_zero_d  = 1'b0;
                    end
                end
            end
            S_DONE: begin
                // Leaving DONE is never an accept edge; idle must be seen first.
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_sh_q      <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            q_sh_q      <= q_sh_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign Quotient  = quotient_q;
    assign Remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_div.sv
// ---------------------------------------------------------------------------
// tb_seq_div - scoreboard bench for seq_div
//
// The driver pushes the reference result and the accept-edge number for every
// request. The monitor pops an entry on each done pulse. It checks the value,
// the latency and the busy duration. Between pulses it checks that the outputs
// hold.
// ---------------------------------------------------------------------------
module tb_seq_div;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] Dividend;
    logic [3:0] Divisor;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] Quotient;
    logic [3:0] Remainder;
    logic       div_zero;

    seq_div #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge n, cyc == n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input int a, input int d, input int acc);
        exp_t e;
        if (d == 0) begin
            e.q  = 8'hFF;
            e.r  = 4'd0;
            e.dz = 1'b1;
        end else begin
            e.q  = 8'(a / d);
            e.r  = 4'(a % d);
            e.dz = 1'b0;
        end
        e.acc = acc;
        return e;
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t       e;
        logic [7:0] last_q  = '0;
        logic [3:0] last_r  = '0;
        logic       last_dz = 1'b0;
        int         busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                last_q   = '0;
                last_r   = '0;
                last_dz  = 1'b0;
                busy_cnt = 0;
            end else if (done) begin
                chk("done_has_request", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("quotient", int'(Quotient), int'(e.q));
                    chk("remainder", int'(Remainder), int'(e.r));
                    chk("div_zero", int'(div_zero), int'(e.dz));
                    chk("latency_edge", cyc, e.acc + 8);
                    chk("busy_cycles", busy_cnt, 8);
                    chk("ready_low_in_done", int'(ready), 0);
                    last_q  = e.q;
                    last_r  = e.r;
                    last_dz = e.dz;
                end
                busy_cnt = 0;
            end else begin
                chk("hold_quotient", int'(Quotient), int'(last_q));
                chk("hold_remainder", int'(Remainder), int'(last_r));
                chk("hold_div_zero", int'(div_zero), int'(last_dz));
                chk("ready_xor_busy", int'(ready ^ busy), 1);
                if (busy) busy_cnt++;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) return;
        end
        checks++;
        errors++;
        $display("FAIL ready_timeout actual=0 required=1 (t=%0t)", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "ready never asserted");
    endtask

    // Issue one op; afterwards scramble operands and toggle start through
    // RUN/DONE, releasing start before the next idle edge.
    task automatic do_op(input int a, input int d);
        wait_ready();
        Dividend = 8'(a);
        Divisor  = 4'(d);
        start    = 1'b1;
        sb.push_back(model(a, d, cyc + 1));
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            start    = 1'($urandom_range(0, 1));
            Dividend = 8'($urandom);
            Divisor  = 4'($urandom);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic check_zeroed(input string tag);
        chk({tag, "_ready"}, int'(ready), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_quotient"}, int'(Quotient), 0);
        chk({tag, "_remainder"}, int'(Remainder), 0);
        chk({tag, "_div_zero"}, int'(div_zero), 0);
    endtask

    int dir_a[7] = '{200, 255, 255, 5, 0, 100, 100};
    int dir_d[7] = '{7,   15,  1,   9, 3, 0,   10};

    initial begin : driver
        int base;
        rst      = 1'b1;
        start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zeroed("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 7; i++) do_op(dir_a[i], dir_d[i]);

        for (int a = 0; a < 256; a++)
            for (int d = 0; d < 16; d++)
                do_op(a, d);

        for (int i = 0; i < 40; i++) do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));

        // start held high: accepts every 10 edges
        wait_ready();
        Dividend = 8'd200;
        Divisor  = 4'd7;
        start    = 1'b1;
        base     = cyc + 1;
        for (int k = 0; k < 4; k++) sb.push_back(model(200, 7, base + 10 * k));
        repeat (35) @(posedge clk);
        #1 start = 1'b0;

        // reset during RUN cycle 4 aborts the op without a done pulse
        wait_ready();
        Dividend = 8'd200;
        Divisor  = 4'd7;
        start    = 1'b1;
        sb.push_back(model(200, 7, cyc + 1));
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zeroed("abort");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        do_op(100, 10);

        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        finish_run();
    end

endmodule
